// File: rtl/sim_run_ctrl.sv
// Run controller for CPU simulation harnesses: sequences the CPU reset, counts
// RUN cycles, detects a PC self-loop or explicit halt, and enforces a cycle limit.
//
// state   | meaning
// S_HOLD  | CPU held in reset for RST_CYCLES edges
// S_RUN   | CPU running, cycles counted, PC watched for a self-loop
// S_DONE  | halt seen, outputs frozen until restart
// S_TO    | cycle limit reached, outputs frozen until restart
module sim_run_ctrl #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 10000,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_halt_req,
    input  logic             i_restart,
    output logic             o_cpu_reset,
    output logic             o_running,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [PC_W-1:0]  o_halt_pc
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(HALT_REPEAT) + 1;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TO   = 2'd3
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic [HW-1:0]    r_hold_cnt,   w_hold_nxt;
    logic [SW-1:0]    r_stable_cnt, w_stable_nxt;
    logic             r_first,      w_first_nxt;
    logic [PC_W-1:0]  r_last_pc,    w_last_pc_nxt;
    logic             r_cpu_reset,  w_cpu_reset_nxt;
    logic             r_running,    w_running_nxt;
    logic             r_done,       w_done_nxt;
    logic             r_timeout,    w_timeout_nxt;
    logic [CNT_W-1:0] r_cycle_count, w_cycle_nxt;
    logic [PC_W-1:0]  r_halt_pc,    w_halt_pc_nxt;
    logic             w_same_pc;
    logic             w_halt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_stable_cnt  <= '0;
            r_first       <= 1'b1;
            r_last_pc     <= '0;
            r_cpu_reset   <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_halt_pc     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_stable_cnt  <= w_stable_nxt;
            r_first       <= w_first_nxt;
            r_last_pc     <= w_last_pc_nxt;
            r_cpu_reset   <= w_cpu_reset_nxt;
            r_running     <= w_running_nxt;
            r_done        <= w_done_nxt;
            r_timeout     <= w_timeout_nxt;
            r_cycle_count <= w_cycle_nxt;
            r_halt_pc     <= w_halt_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_stable_nxt    = r_stable_cnt;
        w_first_nxt     = r_first;
        w_last_pc_nxt   = r_last_pc;
        w_cpu_reset_nxt = r_cpu_reset;
        w_running_nxt   = r_running;
        w_done_nxt      = r_done;
        w_timeout_nxt   = r_timeout;
        w_cycle_nxt     = r_cycle_count;
        w_halt_pc_nxt   = r_halt_pc;
        w_same_pc       = 1'b0;
        w_halt          = 1'b0;

        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == HW'(RST_CYCLES - 1)) begin
                    w_state_nxt     = S_RUN;
                    w_cpu_reset_nxt = 1'b0;
                    w_running_nxt   = 1'b1;
                    w_first_nxt     = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_nxt   = r_cycle_count + 1'b1;
                w_last_pc_nxt = i_pc;
                // The first RUN edge has no valid previous sample to compare with.
                w_same_pc = !r_first && (i_pc == r_last_pc);
                if (r_first) begin
                    w_stable_nxt = '0;
                    w_first_nxt  = 1'b0;
                end else if (w_same_pc) begin
                    w_stable_nxt = r_stable_cnt + 1'b1;
                end else begin
                    w_stable_nxt = '0;
                end
                w_halt = i_halt_req || (w_same_pc && (r_stable_cnt == SW'(HALT_REPEAT - 2)));
                if (w_halt) begin
                    w_state_nxt   = S_DONE;
                    w_running_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_halt_pc_nxt = i_pc;
                end else if (r_cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    w_state_nxt   = S_TO;
                    w_running_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DONE, S_TO: begin
                if (i_restart) begin
                    w_state_nxt     = S_HOLD;
                    w_cpu_reset_nxt = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_cycle_nxt     = '0;
                    w_hold_nxt      = '0;
                    w_stable_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    assign o_cpu_reset   = r_cpu_reset;
    assign o_running     = r_running;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_cycle_count;
    assign o_halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl (MAX_CYCLES overridden to 20): reset hold,
// self-loop halt, timeout, halt/limit tie, restart and mid-run async reset.
module tb_sim_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        halt_req;
    logic        restart;
    logic        cpu_reset;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] halt_pc;

    int checks   = 0;
    int failures = 0;

    sim_run_ctrl #(.MAX_CYCLES(20)) u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pc          (pc),
        .i_halt_req    (halt_req),
        .i_restart     (restart),
        .o_cpu_reset   (cpu_reset),
        .o_running     (running),
        .o_done        (done),
        .o_timeout     (timeout),
        .o_cycle_count (cycle_count),
        .o_halt_pc     (halt_pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic cr, input logic rn,
                                input logic dn, input logic to, input logic [31:0] cnt);
        check_val({tag, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
        check_val({tag, ".running"},   {31'd0, running},   {31'd0, rn});
        check_val({tag, ".done"},      {31'd0, done},      {31'd0, dn});
        check_val({tag, ".timeout"},   {31'd0, timeout},   {31'd0, to});
        check_val({tag, ".count"},     cycle_count,        cnt);
    endtask

    task automatic do_restart_and_hold();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_status("rst_hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        check_status("rst_hold2", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        check_status("rst_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    logic [31:0] halt_seq [8] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C,
                                  32'h3010, 32'h3010, 32'h3010, 32'h3010};

    initial begin
        reset    = 1'b1;
        pc       = 32'h0;
        halt_req = 1'b0;
        restart  = 1'b0;
        #1;
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("reset.halt_pc", halt_pc, 32'h0);
        #2 reset = 1'b0;

        // Hold: two edges with cpu_reset high, RUN entered on the second.
        tick();
        check_status("hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        check_status("hold2", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Self-loop halt on the 4th identical sample (RUN edge 8); restart ignored in RUN.
        for (int i = 0; i < 8; i++) begin
            pc      = halt_seq[i];
            restart = (i == 2);
            tick();
            restart = 1'b0;
            if (i == 0) check_val("run.first_count", cycle_count, 32'd1);
            if (i == 2) check_status("run.restart_ign", 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
            if (i == 6) check_val("run.not_yet_done", {31'd0, done}, 32'd0);
        end
        check_status("halt", 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
        check_val("halt.pc", halt_pc, 32'h3010);

        // DONE is frozen: pc and halt_req ignored.
        for (int i = 0; i < 5; i++) begin
            pc       = 32'h5000 + 32'(i * 4);
            halt_req = 1'b1;
            tick();
        end
        halt_req = 1'b0;
        check_status("done_frozen", 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
        check_val("done_frozen.pc", halt_pc, 32'h3010);

        // Restart re-runs the hold sequence; halt_pc kept.
        do_restart_and_hold();
        check_val("restart.halt_pc_kept", halt_pc, 32'h3010);

        // Timeout with a PC that never repeats.
        for (int i = 0; i < 20; i++) begin
            pc = 32'h100 + 32'(i * 4);
            tick();
            if (i == 18) check_status("pre_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 32'd19);
        end
        check_status("timeout", 1'b0, 1'b0, 1'b0, 1'b1, 32'd20);
        for (int i = 0; i < 50; i++) begin
            pc = 32'h900 + 32'(i * 4);
            tick();
        end
        check_status("timeout_held", 1'b0, 1'b0, 1'b0, 1'b1, 32'd20);
        check_val("timeout.halt_pc", halt_pc, 32'h3010);

        // halt_req on the limit edge: halt wins.
        do_restart_and_hold();
        for (int i = 0; i < 20; i++) begin
            pc       = 32'h200 + 32'(i * 4);
            halt_req = (i == 19);
            tick();
        end
        halt_req = 1'b0;
        check_status("tie", 1'b0, 1'b0, 1'b1, 1'b0, 32'd20);
        check_val("tie.halt_pc", halt_pc, 32'h24C);

        // Async reset at RUN edge 7.
        do_restart_and_hold();
        for (int i = 0; i < 7; i++) begin
            pc = 32'h400 + 32'(i * 4);
            tick();
        end
        check_status("pre_areset", 1'b0, 1'b1, 1'b0, 1'b0, 32'd7);
        #2 reset = 1'b1;
        #1;
        check_status("areset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("areset.halt_pc", halt_pc, 32'h0);
        #2 reset = 1'b0;
        tick();
        check_status("post_hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        check_status("post_hold2", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        pc = 32'h600;
        tick();
        check_val("post_run.count", cycle_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised run controller for simulation harnesses of the single-cycle/pipelined MIPS cores.
- Replaces the fixed inline reset pulse and free-running clock assumption of earlier benches with:
  - a programmable reset-hold sequence;
  - a retired-cycle counter;
  - self-loop halt detection on the PC;
  - a cycle-limit watchdog.
- Sits between the bench clock/reset and the CPU under test. Drives the CPU reset and reports run status for the bench to finish on.

Parameters:
- RST_CYCLES, 2, rising edges cpu_reset stays high after reset deasserts; legal range ≥1.
- MAX_CYCLES, 10000, RUN edges before timeout; must be < 2^CNT_W.
- CNT_W, 32, width of cycle_count.
- PC_W, 32, width of pc and halt_pc.
- HALT_REPEAT, 4, consecutive equal PC samples that declare a halt; legal range ≥2.

Ports:
- clk  in  1  bench clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- pc  in  PC_W  current PC of the CPU under test.
- halt_req  in  1  explicit halt request, e.g. from a syscall/eret decode.
- restart  in  1  single-cycle pulse; re-runs from DONE/TIMEOUT.
- cpu_reset  out  1  reset to the CPU, active-high.
- running  out  1  high while in RUN.
- done  out  1  high in DONE (halt seen).
- timeout  out  1  high in TIMEOUT (limit reached).
- cycle_count  out  CNT_W  RUN edges elapsed.
- halt_pc  out  PC_W  PC captured at halt.

Behaviour:
- All outputs are registered. There is one clock domain.
- Async reset (reset=1):
  - state=HOLD, hold_cnt=0, stable_cnt=0, first=1;
  - cpu_reset=1, running=0, done=0, timeout=0, cycle_count=0, halt_pc=0.
- HOLD:
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==RST_CYCLES-1: go to RUN, cpu_reset<=0, running<=1, first<=1.
  - Result: cpu_reset is high for exactly RST_CYCLES edges after reset falls.
- RUN, each edge:
  - cycle_count<=cycle_count+1 and last_pc<=pc.
  - If first=1: stable_cnt<=0 and first<=0. No comparison is made on this edge.
  - Else if pc==last_pc: stable_cnt<=stable_cnt+1. Else: stable_cnt<=0.
  - Halt condition: halt_req=1, or (first=0 and pc==last_pc and stable_cnt==HALT_REPEAT-2). The second case means HALT_REPEAT consecutive identical samples.
  - On halt: go to DONE, running<=0, done<=1, halt_pc<=pc.
  - Else if cycle_count==MAX_CYCLES-1: go to TIMEOUT, running<=0, timeout<=1.
  - On simultaneous halt and limit, halt wins: done=1, timeout=0.
  - cycle_count on the exit edge still increments. On halt at edge N (counting from 1), the final value is N. Timeout final value = MAX_CYCLES.
- DONE / TIMEOUT:
  - Terminal. cycle_count, halt_pc, done and timeout are frozen; cpu_reset stays 0.
  - pc and halt_req are ignored.
- restart:
  - In DONE or TIMEOUT: next edge returns to HOLD, with cpu_reset<=1, done<=0, timeout<=0, cycle_count<=0, hold_cnt<=0, stable_cnt<=0. halt_pc keeps its value until the next halt.
  - In HOLD or RUN: ignored.
- Reset mid-RUN: immediate async return to the reset values above; the sequence restarts from HOLD.
- Widths:
  - cycle_count does not wrap inside the legal MAX_CYCLES range.
  - stable_cnt is $clog2(HALT_REPEAT)+1 bits.
  - pc comparison is over the full PC_W bits.
- No X propagation: an X on pc in HOLD is not sampled. Sampling starts on the first RUN edge.

Test Plan:
- Reset 3 ns, defaults → cpu_reset high for 2 edges, then low. running=1. cycle_count=1 after the first RUN edge.
- pc increments by 4 each edge from 0x3000, then sticks at 0x3010 → done=1 on the 4th equal sample. halt_pc=0x3010. running=0. cycle_count frozen at the exit edge value.
- Override MAX_CYCLES=20 with pc always changing → timeout=1 exactly when cycle_count=20. done stays 0. State is held for 50 further edges.
- halt_req pulse on the same edge cycle_count==MAX_CYCLES-1 → done=1, timeout=0.
- Pulse restart after DONE → cpu_reset high for RST_CYCLES edges, cycle_count=0, then RUN resumes. restart pulsed during RUN has no effect.
- Assert reset at RUN edge 7 → all outputs return to reset values asynchronously, before the next clk edge. Release reset → normal HOLD sequence.
